// File: rtl/replacement_fill_sequencer_if.sv
// Miss, hit, replacement-controller, writeback, fill and tag-write signals
// of the replacement fill sequencer; the slave modport is the sequencer side.
interface replacement_fill_sequencer_if #(
    parameter int NUMBER_OF_WAYS = 8,
    parameter int INDEX_BITS     = 8,
    parameter int TAG_BITS       = 20
);
    logic                      miss_valid;
    logic                      miss_ready;
    logic [INDEX_BITS-1:0]     miss_index;
    logic [TAG_BITS-1:0]       miss_tag;
    logic [NUMBER_OF_WAYS-1:0] ways_valid;
    logic [NUMBER_OF_WAYS-1:0] ways_dirty;
    logic                      hit_valid;
    logic                      hit_ready;
    logic [NUMBER_OF_WAYS-1:0] hit_way;
    logic [NUMBER_OF_WAYS-1:0] rc_ways_in_use;
    logic [NUMBER_OF_WAYS-1:0] rc_current_access;
    logic                      rc_access_valid;
    logic [NUMBER_OF_WAYS-1:0] rc_selected_way;
    logic                      wb_req;
    logic [NUMBER_OF_WAYS-1:0] wb_way;
    logic [INDEX_BITS-1:0]     wb_index;
    logic                      wb_ack;
    logic                      fill_req;
    logic [INDEX_BITS-1:0]     fill_index;
    logic [TAG_BITS-1:0]       fill_tag;
    logic                      fill_ack;
    logic                      tag_we;
    logic [NUMBER_OF_WAYS-1:0] tag_way;
    logic [INDEX_BITS-1:0]     tag_index;
    logic [TAG_BITS-1:0]       tag_value;
    logic                      done;
    logic                      report;

    modport master (
        output miss_valid, miss_index, miss_tag, ways_valid, ways_dirty,
        output hit_valid, hit_way, rc_selected_way, wb_ack, fill_ack, report,
        input  miss_ready, hit_ready, rc_ways_in_use, rc_current_access,
        input  rc_access_valid, wb_req, wb_way, wb_index, fill_req,
        input  fill_index, fill_tag, tag_we, tag_way, tag_index, tag_value,
        input  done
    );

    modport slave (
        input  miss_valid, miss_index, miss_tag, ways_valid, ways_dirty,
        input  hit_valid, hit_way, rc_selected_way, wb_ack, fill_ack, report,
        output miss_ready, hit_ready, rc_ways_in_use, rc_current_access,
        output rc_access_valid, wb_req, wb_way, wb_index, fill_req,
        output fill_index, fill_tag, tag_we, tag_way, tag_index, tag_value,
        output done
    );
endinterface

// File: rtl/replacement_fill_sequencer.sv
// Cache miss sequencer: victim select, dirty writeback, fill, tag/LRU update.
// Optional statistics counters and report printing under FILL_SEQ_STATS_EN.
module replacement_fill_sequencer #(
    parameter int NUMBER_OF_WAYS = 8,
    parameter int INDEX_BITS     = 8,
    parameter int TAG_BITS       = 20
) (
    input logic clock,
    input logic reset,
    replacement_fill_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, SELECT, WRITEBACK, FILL, UPDATE
    } state_e;

    localparam logic [NUMBER_OF_WAYS-1:0] WAY0 =
        {{(NUMBER_OF_WAYS-1){1'b0}}, 1'b1};

    state_e                    state_q, state_d;
    logic [INDEX_BITS-1:0]     index_q, index_d;
    logic [TAG_BITS-1:0]       tag_q, tag_d;
    logic [NUMBER_OF_WAYS-1:0] valid_q, valid_d;
    logic [NUMBER_OF_WAYS-1:0] dirty_q, dirty_d;
    logic [NUMBER_OF_WAYS-1:0] victim_q, victim_d;
    logic [NUMBER_OF_WAYS-1:0] sel_low, victim_norm;
    logic                      accept;

    // Isolate the lowest set bit; an empty selection falls back to way 0.
    assign sel_low     = bus.rc_selected_way & (~bus.rc_selected_way + WAY0);
    assign victim_norm = (sel_low == '0) ? WAY0 : sel_low;
    assign accept      = (state_q == IDLE) && bus.miss_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            index_q  <= '0;
            tag_q    <= '0;
            valid_q  <= '0;
            dirty_q  <= '0;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            tag_q    <= tag_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            victim_q <= victim_d;
        end
    end

    always_comb begin
        state_d               = state_q;
        index_d               = index_q;
        tag_d                 = tag_q;
        valid_d               = valid_q;
        dirty_d               = dirty_q;
        victim_d              = victim_q;
        bus.miss_ready        = 1'b0;
        bus.hit_ready         = 1'b1;
        bus.rc_ways_in_use    = valid_q;
        bus.rc_access_valid   = bus.hit_valid;
        bus.rc_current_access = bus.hit_way;
        bus.wb_req            = 1'b0;
        bus.wb_way            = '0;
        bus.wb_index          = '0;
        bus.fill_req          = 1'b0;
        bus.fill_index        = '0;
        bus.fill_tag          = '0;
        bus.tag_we            = 1'b0;
        bus.tag_way           = '0;
        bus.tag_index         = '0;
        bus.tag_value         = '0;
        bus.done              = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.miss_ready     = 1'b1;
                bus.rc_ways_in_use = '0;
                if (accept) begin
                    index_d = bus.miss_index;
                    tag_d   = bus.miss_tag;
                    valid_d = bus.ways_valid;
                    dirty_d = bus.ways_dirty;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                victim_d = victim_norm;
                if ((victim_norm & valid_q & dirty_q) != '0)
                    state_d = WRITEBACK;
                else
                    state_d = FILL;
            end
            WRITEBACK: begin
                bus.wb_req   = 1'b1;
                bus.wb_way   = victim_q;
                bus.wb_index = index_q;
                if (bus.wb_ack)
                    state_d = FILL;
            end
            FILL: begin
                bus.fill_req   = 1'b1;
                bus.fill_index = index_q;
                bus.fill_tag   = tag_q;
                if (bus.fill_ack)
                    state_d = UPDATE;
            end
            UPDATE: begin
                bus.hit_ready         = 1'b0;
                bus.rc_access_valid   = 1'b1;
                bus.rc_current_access = victim_q;
                bus.tag_we            = 1'b1;
                bus.tag_way           = victim_q;
                bus.tag_index         = index_q;
                bus.tag_value         = tag_q;
                bus.done              = 1'b1;
                state_d               = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef FILL_SEQ_STATS_EN
    logic [31:0] cycles_q, misses_q, wbs_q, stalls_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cycles_q <= '0;
            misses_q <= '0;
            wbs_q    <= '0;
            stalls_q <= '0;
        end else begin
            cycles_q <= cycles_q + 32'd1;
            if (accept)
                misses_q <= misses_q + 32'd1;
            if (state_q == WRITEBACK && bus.wb_ack)
                wbs_q <= wbs_q + 32'd1;
            if (state_q != IDLE)
                stalls_q <= stalls_q + 32'd1;
            if (bus.report)
                $display("stats: cycles=%0d misses=%0d writebacks=%0d stalls=%0d state=%s",
                         cycles_q, misses_q, wbs_q, stalls_q, state_q.name());
        end
    end
`else
    logic unused_report;
    assign unused_report = bus.report;
`endif
endmodule

// File: tb/tb_replacement_fill_sequencer.sv
// Randomized bench: a timeline model derives per-cycle expected outputs
// for each miss from victim choice and the chosen ack delays.
module tb_replacement_fill_sequencer;
    localparam int W  = 8;
    localparam int IB = 8;
    localparam int TB = 20;

    localparam int PH_IDLE = 0;
    localparam int PH_SEL  = 1;
    localparam int PH_WB   = 2;
    localparam int PH_FILL = 3;
    localparam int PH_UPD  = 4;

    logic clock;
    logic reset;
    int   errors;
    int   checks;

    logic [IB-1:0] exp_idx;
    logic [TB-1:0] exp_tag;
    logic [W-1:0]  exp_valid;

    replacement_fill_sequencer_if #(
        .NUMBER_OF_WAYS(W), .INDEX_BITS(IB), .TAG_BITS(TB)
    ) bus ();

    replacement_fill_sequencer #(
        .NUMBER_OF_WAYS(W), .INDEX_BITS(IB), .TAG_BITS(TB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model_victim(input logic [W-1:0] sel);
        for (int i = 0; i < W; i++)
            if (sel[i]) return W'(1) << i;
        return W'(1);
    endfunction

    task automatic noise(input int ph);
        bus.hit_valid = 1'($urandom_range(0, 1));
        bus.hit_way   = W'(1) << $urandom_range(0, W - 1);
        bus.wb_ack    = (ph == PH_WB)   ? 1'b0 : 1'($urandom_range(0, 1));
        bus.fill_ack  = (ph == PH_FILL) ? 1'b0 : 1'($urandom_range(0, 1));
    endtask

    task automatic cycle(input int ph, input logic [W-1:0] vic);
        @(negedge clock);
        chk("miss_ready", 32'(bus.miss_ready), 32'(ph == PH_IDLE));
        chk("hit_ready", 32'(bus.hit_ready), 32'(ph != PH_UPD));
        chk("rc_ways_in_use", 32'(bus.rc_ways_in_use),
            (ph == PH_IDLE) ? 32'd0 : 32'(exp_valid));
        chk("rc_access_valid", 32'(bus.rc_access_valid),
            (ph == PH_UPD) ? 32'd1 : 32'(bus.hit_valid));
        chk("rc_current_access", 32'(bus.rc_current_access),
            (ph == PH_UPD) ? 32'(vic) : 32'(bus.hit_way));
        chk("wb_req", 32'(bus.wb_req), 32'(ph == PH_WB));
        chk("wb_way", 32'(bus.wb_way), (ph == PH_WB) ? 32'(vic) : 32'd0);
        chk("wb_index", 32'(bus.wb_index), (ph == PH_WB) ? 32'(exp_idx) : 32'd0);
        chk("fill_req", 32'(bus.fill_req), 32'(ph == PH_FILL));
        chk("fill_index", 32'(bus.fill_index),
            (ph == PH_FILL) ? 32'(exp_idx) : 32'd0);
        chk("fill_tag", 32'(bus.fill_tag), (ph == PH_FILL) ? 32'(exp_tag) : 32'd0);
        chk("tag_we", 32'(bus.tag_we), 32'(ph == PH_UPD));
        chk("tag_way", 32'(bus.tag_way), (ph == PH_UPD) ? 32'(vic) : 32'd0);
        chk("tag_index", 32'(bus.tag_index), (ph == PH_UPD) ? 32'(exp_idx) : 32'd0);
        chk("tag_value", 32'(bus.tag_value), (ph == PH_UPD) ? 32'(exp_tag) : 32'd0);
        chk("done", 32'(bus.done), 32'(ph == PH_UPD));
        @(posedge clock);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        bus.miss_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            noise(PH_IDLE);
            bus.miss_index = IB'($urandom);
            cycle(PH_IDLE, '0);
        end
    endtask

    // abort: reset is asserted in the first writeback cycle of a dirty miss
    task automatic run_miss(input logic [IB-1:0] idx, input logic [TB-1:0] tag,
                            input logic [W-1:0] val, input logic [W-1:0] dir,
                            input logic [W-1:0] sel, input int wd, input int fd,
                            input bit abort);
        logic [W-1:0] vic;
        bit           dirty;
        vic = model_victim(sel);
        dirty = 1'b0;
        for (int i = 0; i < W; i++)
            if (vic[i] && val[i] && dir[i]) dirty = 1'b1;
        bus.miss_valid = 1'b1;
        bus.miss_index = idx;
        bus.miss_tag   = tag;
        bus.ways_valid = val;
        bus.ways_dirty = dir;
        noise(PH_IDLE);
        cycle(PH_IDLE, vic);
        exp_idx   = idx;
        exp_tag   = tag;
        exp_valid = val;
        bus.miss_valid = 1'b0;
        bus.miss_index = IB'($urandom);
        bus.miss_tag   = TB'($urandom);
        bus.ways_valid = W'($urandom);
        bus.ways_dirty = W'($urandom);
        bus.rc_selected_way = sel;
        noise(PH_SEL);
        cycle(PH_SEL, vic);
        bus.rc_selected_way = W'($urandom);
        if (dirty) begin
            for (int i = 0; i <= wd; i++) begin
                noise(PH_WB);
                bus.wb_ack = (i == wd);
                if (abort) begin
                    bus.wb_ack = 1'b0;
                    reset = 1'b1;
                    cycle(PH_WB, vic);
                    reset = 1'b0;
                    idle_cycles(4);
                    return;
                end
                cycle(PH_WB, vic);
            end
        end
        for (int i = 0; i <= fd; i++) begin
            noise(PH_FILL);
            bus.fill_ack = (i == fd);
            cycle(PH_FILL, vic);
        end
        noise(PH_UPD);
        cycle(PH_UPD, vic);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        exp_idx = '0;
        exp_tag = '0;
        exp_valid = '0;
        reset = 1'b1;
        bus.miss_valid = 1'b0;
        bus.miss_index = '0;
        bus.miss_tag = '0;
        bus.ways_valid = '0;
        bus.ways_dirty = '0;
        bus.hit_valid = 1'b0;
        bus.hit_way = '0;
        bus.rc_selected_way = '0;
        bus.wb_ack = 1'b0;
        bus.fill_ack = 1'b0;
        bus.report = 1'b0;
        @(posedge clock);
        #1;
        cycle(PH_IDLE, '0);
        reset = 1'b0;
        idle_cycles(2);

        run_miss(8'h12, 20'hABCDE, 8'h0F, 8'h00, 8'h10, 0, 1, 0);
        idle_cycles(1);
        run_miss(8'h34, 20'h12345, 8'hFF, 8'h04, 8'h04, 2, 0, 0);
        idle_cycles(1);
        run_miss(8'h56, 20'h0F0F0, 8'hFF, 8'h00, 8'h00, 0, 0, 0);
        run_miss(8'h78, 20'hFFFFF, 8'hFF, 8'h20, 8'h30, 0, 2, 0);
        run_miss(8'h9A, 20'h55555, 8'hFF, 8'hFF, 8'h08, 1, 0, 1);
        run_miss(8'hBC, 20'hAAAAA, 8'h01, 8'h01, 8'h00, 0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            logic [W-1:0] sel;
            sel = ($urandom_range(0, 2) == 0) ? W'($urandom)
                                              : W'(1) << $urandom_range(0, W - 1);
            run_miss(IB'($urandom), TB'($urandom), W'($urandom | 32'hC3),
                     W'($urandom), sel, $urandom_range(0, 3),
                     $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
            idle_cycles($urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/replacement_fill_sequencer.md
Name: replacement_fill_sequencer

Overview:
- Miss-handling controller that sequences the way-replacement controller for a set-associative cache level.
- On a miss it drives the set's occupancy to the replacement controller and captures the selected victim way.
- It writes back a dirty victim, requests the line fill, then updates tag state and replacement (LRU) state in one cycle.
- It also arbitrates hit-access LRU updates against its own update.

Parameters:
NUMBER_OF_WAYS, 8, associativity; width of all one-hot way vectors
INDEX_BITS, 8, set index width
TAG_BITS, 20, tag width

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
miss_valid  input  1  miss request
miss_ready  output  1  sequencer idle, can accept a miss
miss_index  input  INDEX_BITS  set index of miss
miss_tag  input  TAG_BITS  tag of missing line
ways_valid  input  NUMBER_OF_WAYS  valid bits of the missed set, sampled at accept
ways_dirty  input  NUMBER_OF_WAYS  dirty bits of the missed set, sampled at accept
hit_valid  input  1  hit LRU-update request
hit_ready  output  1  hit update accepted this cycle
hit_way  input  NUMBER_OF_WAYS  one-hot hit way
rc_ways_in_use  output  NUMBER_OF_WAYS  to replacement controller ways_in_use
rc_current_access  output  NUMBER_OF_WAYS  to replacement controller current_access
rc_access_valid  output  1  to replacement controller access_valid
rc_selected_way  input  NUMBER_OF_WAYS  from replacement controller selected_way
wb_req  output  1  writeback request
wb_way  output  NUMBER_OF_WAYS  victim way to write back
wb_index  output  INDEX_BITS  victim set
wb_ack  input  1  writeback complete
fill_req  output  1  line fill request
fill_index  output  INDEX_BITS  fill set
fill_tag  output  TAG_BITS  fill tag
fill_ack  input  1  fill data written
tag_we  output  1  tag-array write strobe: set valid, clear dirty
tag_way  output  NUMBER_OF_WAYS  way written
tag_index  output  INDEX_BITS  set written
tag_value  output  TAG_BITS  tag written
done  output  1  miss complete pulse
report  input  1  print statistics (see optional feature)

Behaviour:
- States: IDLE, SELECT, WRITEBACK, FILL, UPDATE. Reset enters IDLE.
- Reset values:
  - all req, strobe and done outputs = 0; miss_ready = 1; hit_ready = 1;
  - rc_ways_in_use, rc_current_access, wb_way and tag_way = 0;
  - index and tag outputs = 0.
- IDLE:
  - miss_ready = 1.
  - On miss_valid & miss_ready: register index, tag, ways_valid and ways_dirty, then go to SELECT.
- SELECT (exactly 1 cycle):
  - rc_ways_in_use = registered ways_valid. It is also driven with the registered value in every other non-IDLE state, and is 0 in IDLE.
  - Register victim = rc_selected_way, normalised: multiple bits set -> keep lowest set bit; all zero -> way 0.
  - If victim is valid & dirty -> WRITEBACK; otherwise -> FILL.
- WRITEBACK:
  - wb_req held high with wb_way = victim and wb_index = registered index until wb_ack.
  - wb_ack may arrive in the same cycle wb_req first rises.
  - On wb_ack -> FILL; wb_req is low the next cycle.
- FILL:
  - fill_req held high with registered index and tag until fill_ack, same rules as WRITEBACK.
  - On fill_ack -> UPDATE.
- UPDATE (exactly 1 cycle):
  - tag_we = 1, tag_way = victim, tag_index and tag_value = registered values.
  - rc_access_valid = 1, rc_current_access = victim.
  - done = 1, then -> IDLE.
- Hit arbitration:
  - In every state except UPDATE: rc_access_valid = hit_valid, rc_current_access = hit_way, hit_ready = 1.
  - In UPDATE: hit_ready = 0; the requester holds the hit to the next cycle.
- Stray acks: wb_ack outside WRITEBACK and fill_ack outside FILL are ignored.
- Latency:
  - Clean miss with immediate fill_ack: accept cycle 0, SELECT 1, FILL 2, UPDATE 3, miss_ready = 1 in cycle 4.
  - Dirty victim adds at least 1 cycle.
- Back-to-back misses: a new miss may be accepted in the cycle after UPDATE.
- Reset mid-operation: immediate return to IDLE, all requests drop, no tag_we and no rc_access_valid.

Optional Feature:
- Macro: FILL_SEQ_STATS_EN.
- Defined:
  - 32-bit counters for cycles, misses accepted, writebacks and stall cycles (miss outstanding, not IDLE), all cleared by reset.
  - While report = 1, $display of all counters and the current state each cycle.
- Undefined: no counters or displays; report is unused; function is otherwise identical.

Test Plan:
- Clean miss: reset, miss index=0x12 tag=0xABCDE, ways_valid=0x0F, rc_selected_way=0x10, fill_ack 1 cycle after fill_req -> no wb_req; fill_req cycle 2; tag_we/done/rc_access_valid in cycle 4 with way 0x10; miss_ready high cycle 5.
- Dirty victim: ways_valid=0xFF, ways_dirty=0x04, rc_selected_way=0x04, wb_ack after 3 cycles -> wb_req 3 cycles with wb_way=0x04, then fill_req, then tag_we way=0x04.
- Selection normalisation: rc_selected_way=0x00 -> victim 0x01; rc_selected_way=0x30 -> victim 0x10.
- Hit collision: hit_valid=1 hit_way=0x02 held through UPDATE -> hit_ready=0 and rc_current_access=victim in UPDATE; next cycle rc_current_access=0x02 with hit_ready=1.
- Reset mid-writeback: assert reset while wb_req=1 -> next cycle wb_req=0, miss_ready=1, no tag_we or done ever seen for that miss.
- With FILL_SEQ_STATS_EN: 3 misses, 1 dirty -> miss counter=3, writeback counter=1 printed on report.
